led_pwm_dimmer: RTL and testbench

Downstream stage of the LED pattern controller. It takes the per-colour on/off outputs of the pattern controller and the register-programmed brightness values, and drives the R/G/B LED pads with PWM. Each channel has its own brightness level and fades linearly toward its target. Clocked from the 12 MHz fabric clock, alongside the pattern controller.

---
 rtl/led_pkg.sv | 26 ++
 rtl/led_pwm_channel.sv | 82 ++++++++
 rtl/led_pwm_dimmer.sv | 134 +++++++++++++
 tb/tb_led_pwm_dimmer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Purpose  : Shared constants and types for the LED PWM dimmer.
//            - default PWM resolution
//            - channel index constants (red, green, blue)
//            - per-channel fade state encoding
// Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int c_PWM_WIDTH = 8;

    localparam int c_NUM_CH = 3;
    localparam int c_CH_R   = 0;
    localparam int c_CH_G   = 1;
    localparam int c_CH_B   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FADE_UP = 2'd1,
        ST_FADE_DN = 2'd2
    } ch_state_e;

endpackage
`default_nettype wire

// File: rtl/led_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_channel
// Purpose  : One colour channel of the dimmer: brightness level register,
//            linear fade stepping toward the target, registered PWM compare.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_pb          - period boundary strobe (level may change only here)
//            i_load        - instant mode: level jumps to target at i_pb
//            i_step_en     - fade mode: step one level toward target at i_pb
//            i_enable      - global output enable
//            i_target      - target level
//            i_pwm_cnt     - shared PWM counter
//            o_pwm         - registered pad drive
//            o_busy        - level differs from target (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_WIDTH = c_PWM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_pb,
    input  logic                 i_load,
    input  logic                 i_step_en,
    input  logic                 i_enable,
    input  logic [PWM_WIDTH-1:0] i_target,
    input  logic [PWM_WIDTH-1:0] i_pwm_cnt,
    output logic                 o_pwm,
    output logic                 o_busy
);

    localparam logic [PWM_WIDTH-1:0] c_ONE      = PWM_WIDTH'(1);
    localparam logic [PWM_WIDTH-1:0] c_ALL_ONES = '1;

    logic [PWM_WIDTH-1:0] r_level;
    logic [PWM_WIDTH-1:0] w_level_nxt;
    ch_state_e            w_state;
    logic                 r_pwm;

    // The fade state is implied by level vs target, so the level register is
    // the state register; a target crossing simply flips the direction.
    always_comb begin
        w_state     = ST_IDLE;
        w_level_nxt = r_level;

        if (i_target > r_level) begin
            w_state = ST_FADE_UP;
        end else if (i_target < r_level) begin
            w_state = ST_FADE_DN;
        end

        if (i_pb) begin
            if (i_load) begin
                w_level_nxt = i_target;
            end else if (i_step_en) begin
                case (w_state)
                    ST_FADE_UP: w_level_nxt = r_level + c_ONE;
                    ST_FADE_DN: w_level_nxt = r_level - c_ONE;
                    default:    w_level_nxt = r_level;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            // Full scale is forced high so the output never dips for one tick.
            r_pwm   <= i_enable && ((r_level == c_ALL_ONES) || (i_pwm_cnt < r_level));
        end
    end

    assign o_pwm  = r_pwm;
    assign o_busy = (w_state != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/led_pwm_dimmer.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_dimmer
// Purpose  : Drives the R/G/B LED pads with PWM. Each channel fades linearly
//            toward led_x_i ? bright_x_i : 0; levels change only on the PWM
//            period boundary so the waveform never glitches.
// Ports    : clk, rst               - 12 MHz fabric clock, sync active-high reset
//            enable_i               - global output enable
//            led_{r,g,b}_i          - on/off from the pattern controller
//            bright_{r,g,b}_i       - target level when on
//            fade_rate_i            - PWM periods per level step, 0 = instant
//            led_{r,g,b}_o          - pad drives
//            fade_busy_o            - any channel level differs from target
// Revision : 1.0 - initial release
// ============================================================================
module led_pwm_dimmer
    import led_pkg::*;
#(
    parameter int PWM_WIDTH    = c_PWM_WIDTH,
    parameter int PRESCALE_DIV = 48,
    parameter int FADE_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  led_r_i,
    input  logic                  led_g_i,
    input  logic                  led_b_i,
    input  logic [PWM_WIDTH-1:0]  bright_r_i,
    input  logic [PWM_WIDTH-1:0]  bright_g_i,
    input  logic [PWM_WIDTH-1:0]  bright_b_i,
    input  logic [FADE_WIDTH-1:0] fade_rate_i,
    output logic                  led_r_o,
    output logic                  led_g_o,
    output logic                  led_b_o,
    output logic                  fade_busy_o
);

    localparam int                    c_PRE_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [c_PRE_W-1:0]    c_PRE_LAST = c_PRE_W'(PRESCALE_DIV - 1);
    localparam logic [c_PRE_W-1:0]    c_PRE_ONE  = c_PRE_W'(1);
    localparam logic [PWM_WIDTH-1:0]  c_PWM_ONE  = PWM_WIDTH'(1);
    localparam logic [PWM_WIDTH-1:0]  c_PWM_LAST = '1;
    localparam logic [FADE_WIDTH:0]   c_FADE_ONE = (FADE_WIDTH+1)'(1);

    logic [c_PRE_W-1:0]    r_presc;
    logic [PWM_WIDTH-1:0]  r_pwm_cnt;
    logic [FADE_WIDTH-1:0] r_fade_cnt;
    logic                  r_busy;

    logic                  w_tick;
    logic                  w_pb;
    logic                  w_rate_zero;
    logic [FADE_WIDTH:0]   w_fade_inc;
    logic                  w_step_en;

    logic [c_NUM_CH-1:0]   w_led;
    logic [c_NUM_CH-1:0]   w_pwm;
    logic [c_NUM_CH-1:0]   w_busy;
    logic [PWM_WIDTH-1:0]  w_bright [c_NUM_CH];

    assign w_tick      = (r_presc == c_PRE_LAST);
    assign w_pb        = w_tick && (r_pwm_cnt == c_PWM_LAST);
    assign w_rate_zero = (fade_rate_i == '0);
    // One extra bit keeps fade_cnt+1 from wrapping when fade_rate_i is max.
    assign w_fade_inc  = {1'b0, r_fade_cnt} + c_FADE_ONE;
    // Using >= means a rate lowered below the running count steps at once.
    assign w_step_en   = !w_rate_zero && (w_fade_inc >= {1'b0, fade_rate_i});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_pwm_cnt  <= '0;
            r_fade_cnt <= '0;
        end else begin
            r_presc <= w_tick ? '0 : (r_presc + c_PRE_ONE);

            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + c_PWM_ONE;
            end

            if (w_pb) begin
                if (w_rate_zero || w_step_en) begin
                    r_fade_cnt <= '0;
                end else begin
                    r_fade_cnt <= w_fade_inc[FADE_WIDTH-1:0];
                end
            end
        end
    end

    assign w_led[c_CH_R]    = led_r_i;
    assign w_led[c_CH_G]    = led_g_i;
    assign w_led[c_CH_B]    = led_b_i;
    assign w_bright[c_CH_R] = bright_r_i;
    assign w_bright[c_CH_G] = bright_g_i;
    assign w_bright[c_CH_B] = bright_b_i;

    for (genvar gi = 0; gi < c_NUM_CH; gi++) begin : g_ch
        logic [PWM_WIDTH-1:0] w_target;

        assign w_target = w_led[gi] ? w_bright[gi] : '0;

        led_pwm_channel #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .i_pb      (w_pb),
            .i_load    (w_rate_zero),
            .i_step_en (w_step_en),
            .i_enable  (enable_i),
            .i_target  (w_target),
            .i_pwm_cnt (r_pwm_cnt),
            .o_pwm     (w_pwm[gi]),
            .o_busy    (w_busy[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_busy;
        end
    end

    assign led_r_o     = w_pwm[c_CH_R];
    assign led_g_o     = w_pwm[c_CH_G];
    assign led_b_o     = w_pwm[c_CH_B];
    assign fade_busy_o = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_dimmer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pwm_dimmer
// Purpose  : Directed self-checking bench for led_pwm_dimmer with
//            PRESCALE_DIV=1 (one PWM period = 256 clk). Expected per-period
//            results are queued when stimulus is applied and checked when the
//            period has been observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pwm_dimmer;

    localparam int PWM_WIDTH    = 8;
    localparam int PRESCALE_DIV = 1;
    localparam int FADE_WIDTH   = 16;
    localparam int PERIOD       = 256;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  enable_i = 1'b0;
    logic                  led_r_i = 1'b0, led_g_i = 1'b0, led_b_i = 1'b0;
    logic [PWM_WIDTH-1:0]  bright_r_i = '0, bright_g_i = '0, bright_b_i = '0;
    logic [FADE_WIDTH-1:0] fade_rate_i = '0;
    logic                  led_r_o, led_g_o, led_b_o, fade_busy_o;

    always #5 clk = ~clk;

    led_pwm_dimmer #(
        .PWM_WIDTH    (PWM_WIDTH),
        .PRESCALE_DIV (PRESCALE_DIV),
        .FADE_WIDTH   (FADE_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable_i),
        .led_r_i     (led_r_i),
        .led_g_i     (led_g_i),
        .led_b_i     (led_b_i),
        .bright_r_i  (bright_r_i),
        .bright_g_i  (bright_g_i),
        .bright_b_i  (bright_b_i),
        .fade_rate_i (fade_rate_i),
        .led_r_o     (led_r_o),
        .led_g_o     (led_g_o),
        .led_b_o     (led_b_o),
        .fade_busy_o (fade_busy_o)
    );

    // Expected results for one PWM period; -1 means "not checked".
    typedef struct {
        int r;      // high clk count of led_r_o
        int g;
        int b;
        int rfl;    // index of first low led_r_o sample
        int bf;     // fade_busy_o at the first sample of the period
        int bl;     // fade_busy_o at the last sample of the period
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   win      = 0;

    task automatic clk1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int r, input int g, input int b,
                        input int rfl, input int bf, input int bl);
        exp_t e;
        e.r = r; e.g = g; e.b = b; e.rfl = rfl; e.bf = bf; e.bl = bl;
        sb.push_back(e);
    endtask

    // Observe one whole PWM period (aligned to pwm_cnt = 0 at the output)
    // and compare it against the oldest queued expectation.
    task automatic run_win();
        int    cr, cg, cb, rfl, bf, bl;
        string tag;
        exp_t  e;
        for (int k = 0; k < PERIOD && (cyc % PERIOD) != 0; k++) clk1();
        cr = 0; cg = 0; cb = 0; rfl = PERIOD; bf = 0; bl = 0;
        for (int i = 0; i < PERIOD; i++) begin
            clk1();
            cr += (led_r_o === 1'b1) ? 1 : 0;
            cg += (led_g_o === 1'b1) ? 1 : 0;
            cb += (led_b_o === 1'b1) ? 1 : 0;
            if (led_r_o !== 1'b1 && rfl == PERIOD) rfl = i;
            if (i == 0)          bf = (fade_busy_o === 1'b1) ? 1 : 0;
            if (i == PERIOD - 1) bl = (fade_busy_o === 1'b1) ? 1 : 0;
        end
        tag = $sformatf("W%0d", win);
        win++;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            if (e.r   >= 0) chk({tag, "_r_high"},    cr,  e.r);
            if (e.g   >= 0) chk({tag, "_g_high"},    cg,  e.g);
            if (e.b   >= 0) chk({tag, "_b_high"},    cb,  e.b);
            if (e.rfl >= 0) chk({tag, "_r_fall"},    rfl, e.rfl);
            if (e.bf  >= 0) chk({tag, "_busy_first"}, bf, e.bf);
            if (e.bl  >= 0) chk({tag, "_busy_last"},  bl, e.bl);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;

        // ---- Reset with every input active ----
        enable_i = 1'b1;
        led_r_i = 1'b1; led_g_i = 1'b1; led_b_i = 1'b1;
        bright_r_i = 8'd255; bright_g_i = 8'd255; bright_b_i = 8'd255;
        fade_rate_i = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk1();
            chk("rst_r",    int'(led_r_o),     0);
            chk("rst_g",    int'(led_g_o),     0);
            chk("rst_b",    int'(led_b_o),     0);
            chk("rst_busy", int'(fade_busy_o), 0);
        end

        // ---- Instant level, red at 64 ----
        led_g_i = 1'b0; led_b_i = 1'b0;
        bright_r_i = 8'd64; bright_g_i = 8'd4; bright_b_i = 8'd255;
        rst = 1'b0;
        cyc = 0;
        push(0, 0, 0, -1, 1, 1);     run_win();   // levels still 0
        push(64, 0, 0, 64, 0, 0);    run_win();   // 64 high then 192 low

        // ---- Extremes on blue ----
        led_b_i = 1'b1;
        push(64, 0, 0, 64, 1, 1);    run_win();
        push(64, 0, 256, 64, 0, 0);  run_win();   // full scale: constant 1
        bright_b_i = 8'd0;
        push(64, 0, 256, 64, 1, 1);  run_win();
        push(64, 0, 0, 64, 0, 0);    run_win();   // zero: constant 0

        // ---- Fade up green 0 -> 4, rate 2 ----
        fade_rate_i = 16'd2;
        led_g_i = 1'b1;
        push(64, 0, 0, 64, 1, 1);    run_win();
        push(64, 0, 0, 64, 1, 1);    run_win();
        push(64, 1, 0, 64, 1, 1);    run_win();
        push(64, 1, 0, 64, 1, 1);    run_win();
        push(64, 2, 0, 64, 1, 1);    run_win();
        push(64, 2, 0, 64, 1, 1);    run_win();
        push(64, 3, 0, 64, 1, 1);    run_win();
        push(64, 3, 0, 64, 1, 1);    run_win();
        push(64, 4, 0, 64, 0, 0);    run_win();   // busy drops after last step

        // ---- Instant clear, then fade up and reverse at level 2 ----
        fade_rate_i = 16'd0;
        led_g_i = 1'b0;
        push(64, 4, 0, 64, 1, 1);    run_win();
        fade_rate_i = 16'd2;
        led_g_i = 1'b1;
        push(-1, 0, -1, -1, 1, 1);   run_win();
        push(-1, 0, -1, -1, 1, 1);   run_win();
        push(-1, 1, -1, -1, 1, 1);   run_win();
        push(-1, 1, -1, -1, 1, 1);   run_win();
        led_g_i = 1'b0;                           // reversal at level 2
        push(-1, 2, -1, -1, 1, 1);   run_win();
        push(-1, 2, -1, -1, 1, 1);   run_win();
        push(-1, 1, -1, -1, 1, 1);   run_win();
        push(-1, 1, -1, -1, 1, 1);   run_win();
        push(-1, 0, -1, -1, 0, 0);   run_win();

        // ---- Fade up again and reset at level 3 ----
        led_g_i = 1'b1;
        push(-1, 0, -1, -1, 1, 1);   run_win();
        push(-1, 1, -1, -1, 1, 1);   run_win();
        push(-1, 1, -1, -1, 1, 1);   run_win();
        push(-1, 2, -1, -1, 1, 1);   run_win();
        push(-1, 2, -1, -1, 1, 1);   run_win();
        clk1();
        clk1();                                   // pwm_cnt 1 < level 3
        chk("pre_rst_g", int'(led_g_o), 1);
        chk("pre_rst_r", int'(led_r_o), 1);
        rst = 1'b1;
        clk1();
        chk("mid_rst_g",    int'(led_g_o),     0);
        chk("mid_rst_r",    int'(led_r_o),     0);
        chk("mid_rst_busy", int'(fade_busy_o), 0);
        fade_rate_i = 16'd0;
        clk1();
        rst = 1'b0;
        cyc = 0;
        push(0, 0, 0, -1, 1, 1);     run_win();   // levels restart from 0
        push(64, 4, 0, 64, 0, 0);    run_win();

        // ---- Enable gating mid-period ----
        while ((cyc % PERIOD) != 10) clk1();
        chk("en_before_r", int'(led_r_o), 1);
        enable_i = 1'b0;
        clk1();
        chk("en_off_r", int'(led_r_o), 0);
        hi = 0;
        for (int k = 0; k < PERIOD && (cyc % PERIOD) != 0; k++) begin
            clk1();
            hi += (led_r_o === 1'b1 || led_g_o === 1'b1 || led_b_o === 1'b1) ? 1 : 0;
        end
        chk("en_off_rest", hi, 0);
        enable_i = 1'b1;
        push(64, 4, 0, 64, 0, 0);    run_win();   // same high time as before

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
